// File: rtl/code_lock_ctrl.sv
// Keypad code lock: collects CODE_LEN digits on enter presses, checks them against CODE,
// then dwells in OPEN / FAIL / LOCKOUT for a fixed cycle count. All outputs are registered.
module code_lock_ctrl #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] CODE           = 16'h1234,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    OPEN_CYCLES    = 50_000_000,
  parameter int                    FAIL_CYCLES    = 25_000_000,
  parameter int                    LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
  output logic       unlocked,
  output logic       error,
  output logic       alarm,
  output logic [3:0] entry_count,
  output logic [3:0] disp_num
);

  localparam int CW    = 4 * CODE_LEN;
  localparam int MAXOF = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
  localparam int MAXC  = (MAXOF > LOCKOUT_CYCLES) ? MAXOF : LOCKOUT_CYCLES;
  localparam int TW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int TRW   = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCKOUT
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  code_q, code_nxt, code_shift;
  logic [3:0]     cnt_nxt, disp_nxt;
  logic [TRW-1:0] tries, tries_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic           enter_q, press, accept;

  // enter_q powers up high so a button held through reset is not seen as a press
  assign press      = enter & ~enter_q;
  assign accept     = press & (digit <= 4'd9);
  assign code_shift = (code_q << 4) | CW'(digit);

  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    cnt_nxt   = entry_count;
    tries_nxt = tries;
    timer_nxt = timer + TW'(1);
    case (state)
      S_IDLE: begin
        cnt_nxt   = 4'd0;
        timer_nxt = '0;
        if (accept) begin
          code_nxt  = code_shift;
          cnt_nxt   = 4'd1;
          state_nxt = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
        end
      end
      S_ENTRY: begin
        timer_nxt = '0;
        if (clear) begin
          state_nxt = S_IDLE;
          code_nxt  = '0;
          cnt_nxt   = 4'd0;
        end else if (accept) begin
          code_nxt = code_shift;
          cnt_nxt  = entry_count + 4'd1;
          if (cnt_nxt == 4'(CODE_LEN)) state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        timer_nxt = '0;
        cnt_nxt   = 4'd0;
        if (code_q == CODE) begin
          state_nxt = S_OPEN;
          tries_nxt = '0;
        end else if (tries == TRW'(MAX_TRIES - 1)) begin
          state_nxt = S_LOCKOUT;
        end else begin
          state_nxt = S_FAIL;
          tries_nxt = tries + TRW'(1);
        end
      end
      S_OPEN: begin
        if (clear || timer == TW'(OPEN_CYCLES - 1)) state_nxt = S_IDLE;
      end
      S_FAIL: begin
        if (timer == TW'(FAIL_CYCLES - 1)) state_nxt = S_IDLE;
      end
      S_LOCKOUT: begin
        if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          tries_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they flip on the same edge as the state
    disp_nxt = 4'h0;
    case (state_nxt)
      S_ENTRY, S_CHECK: disp_nxt = code_nxt[3:0];
      S_OPEN:           disp_nxt = 4'hA;
      S_FAIL:           disp_nxt = 4'hE;
      S_LOCKOUT:        disp_nxt = 4'hF;
      default:          disp_nxt = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      code_q      <= '0;
      tries       <= '0;
      timer       <= '0;
      enter_q     <= 1'b1;
      unlocked    <= 1'b0;
      error       <= 1'b0;
      alarm       <= 1'b0;
      entry_count <= 4'd0;
      disp_num    <= 4'h0;
    end else begin
      state       <= state_nxt;
      code_q      <= code_nxt;
      tries       <= tries_nxt;
      timer       <= timer_nxt;
      enter_q     <= enter;
      unlocked    <= (state_nxt == S_OPEN);
      error       <= (state_nxt == S_FAIL);
      alarm       <= (state_nxt == S_LOCKOUT);
      entry_count <= cnt_nxt;
      disp_num    <= disp_nxt;
    end
  end

endmodule
